// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port scheduler between the CPU fetch stage and the
// write-back stage in front of the mem block. At most one operation is issued
// per cycle. Write-back normally wins, but a streak counter bounds how many
// consecutive write-backs may pass a waiting fetch.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   f_req, f_addr      fetch request / PC, held until f_gnt
//   f_gnt              fetch accepted this cycle (combinational)
//   f_valid            mem instr/imm/data_out hold an accepted fetch's result
//   halt               blocks new fetch grants only
//   wb_req, wb_addr,
//   wb_data            write-back request, held until wb_gnt
//   wb_gnt             write-back accepted this cycle (combinational)
//   mem_*              registered controls to the mem block
module mem_arbiter #(
    parameter int WORD          = 16,
    parameter int WB_MAX_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            f_req,
    input  logic [WORD-1:0] f_addr,
    output logic            f_gnt,
    output logic            f_valid,
    input  logic            halt,
    input  logic            wb_req,
    input  logic [WORD-1:0] wb_addr,
    input  logic [WORD-1:0] wb_data,
    output logic            wb_gnt,
    output logic            mem_fetch,
    output logic [WORD-1:0] mem_fetch_addr,
    output logic            mem_write_back_en,
    output logic [WORD-1:0] mem_write_addr,
    output logic [WORD-1:0] mem_data_in
);

    localparam logic [3:0] STREAK_MAX = 4'(WB_MAX_STREAK);

    logic       ef;
    logic       ew;
    logic       wb_win;
    logic [3:0] streak;

    assign ef = f_req && !halt;
    assign ew = wb_req;

    // Write-back wins unless a fetch is waiting and has already been passed
    // over STREAK_MAX times in a row.
    assign wb_win = ew && (!ef || (streak < STREAK_MAX));
    assign wb_gnt = wb_win;
    assign f_gnt  = ef && !wb_win;

    // Streak only counts write-backs that overtook an eligible fetch; it is
    // meaningless once the fetch goes away or is served, so clear it then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= 4'd0;
        end else if (!ef || f_gnt) begin
            streak <= 4'd0;
        end else if (wb_gnt && (streak < STREAK_MAX)) begin
            streak <= streak + 4'd1;
        end
    end

    // Issue stage: enables pulse for one cycle, address/data hold their last
    // value when idle so mem sees stable inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_fetch         <= 1'b0;
            mem_fetch_addr    <= '0;
            mem_write_back_en <= 1'b0;
            mem_write_addr    <= '0;
            mem_data_in       <= '0;
            f_valid           <= 1'b0;
        end else begin
            mem_fetch         <= f_gnt;
            mem_write_back_en <= wb_gnt;
            if (f_gnt) begin
                mem_fetch_addr <= f_addr;
            end
            if (wb_gnt) begin
                mem_write_addr <= wb_addr;
                mem_data_in    <= wb_data;
            end
            // mem captures at the edge after mem_fetch; result is valid the
            // cycle after that.
            f_valid <= mem_fetch;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int WORD = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            f_req = 1'b0;
    logic [WORD-1:0] f_addr = '0;
    logic            f_gnt;
    logic            f_valid;
    logic            halt = 1'b0;
    logic            wb_req = 1'b0;
    logic [WORD-1:0] wb_addr = '0;
    logic [WORD-1:0] wb_data = '0;
    logic            wb_gnt;
    logic            mem_fetch;
    logic [WORD-1:0] mem_fetch_addr;
    logic            mem_write_back_en;
    logic [WORD-1:0] mem_write_addr;
    logic [WORD-1:0] mem_data_in;

    mem_arbiter #(.WORD(WORD), .WB_MAX_STREAK(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .f_req             (f_req),
        .f_addr            (f_addr),
        .f_gnt             (f_gnt),
        .f_valid           (f_valid),
        .halt              (halt),
        .wb_req            (wb_req),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .wb_gnt            (wb_gnt),
        .mem_fetch         (mem_fetch),
        .mem_fetch_addr    (mem_fetch_addr),
        .mem_write_back_en (mem_write_back_en),
        .mem_write_addr    (mem_write_addr),
        .mem_data_in       (mem_data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        bit              is_f;
        logic [WORD-1:0] addr;
        logic [WORD-1:0] data;
    } iss_t;

    iss_t iq[$];
    int   fq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares registered outputs against the scoreboard each cycle.
    always @(negedge clk) begin
        if (started && rst_n) begin
            chk("excl", 32'(mem_fetch && mem_write_back_en), 32'd0);
            if (iq.size() > 0 && iq[0].cyc == cyc) begin
                iss_t e;
                e = iq.pop_front();
                chk("mem_fetch", 32'(mem_fetch), 32'(e.is_f));
                chk("mem_wb_en", 32'(mem_write_back_en), 32'(!e.is_f));
                if (e.is_f) begin
                    chk("fetch_addr", 32'(mem_fetch_addr), 32'(e.addr));
                end else begin
                    chk("write_addr", 32'(mem_write_addr), 32'(e.addr));
                    chk("data_in", 32'(mem_data_in), 32'(e.data));
                end
            end else begin
                chk("idle_enables", 32'({mem_fetch, mem_write_back_en}), 32'd0);
            end
            if (fq.size() > 0 && fq[0] == cyc) begin
                void'(fq.pop_front());
                chk("f_valid", 32'(f_valid), 32'd1);
            end else begin
                chk("f_valid_idle", 32'(f_valid), 32'd0);
            end
        end
    end

    // One cycle of stimulus with hand-computed expected grants.
    task automatic step(input bit f, input bit h, input bit w,
                        input logic [WORD-1:0] fa, input logic [WORD-1:0] wa,
                        input logic [WORD-1:0] wd, input bit efg, input bit ewg);
        iss_t e;
        @(negedge clk);
        f_req = f; halt = h; wb_req = w;
        f_addr = fa; wb_addr = wa; wb_data = wd;
        #1;
        chk("f_gnt", 32'(f_gnt), 32'(efg));
        chk("wb_gnt", 32'(wb_gnt), 32'(ewg));
        if (efg) begin
            e.cyc = cyc + 1; e.is_f = 1'b1; e.addr = fa; e.data = '0;
            iq.push_back(e);
            fq.push_back(cyc + 2);
        end
        if (ewg) begin
            e.cyc = cyc + 1; e.is_f = 1'b0; e.addr = wa; e.data = wd;
            iq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f_req = 1'b0; wb_req = 1'b0; halt = 1'b0;
        #1;
        chk("rst_mem_fetch", 32'(mem_fetch), 32'd0);
        chk("rst_wb_en", 32'(mem_write_back_en), 32'd0);
        chk("rst_fetch_addr", 32'(mem_fetch_addr), 32'd0);
        chk("rst_write_addr", 32'(mem_write_addr), 32'd0);
        chk("rst_data_in", 32'(mem_data_in), 32'd0);
        chk("rst_f_valid", 32'(f_valid), 32'd0);
        iq.delete();
        fq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        started = 1'b1;
    endtask

    initial begin
        int nf;
        // Asynchronous reset asserted mid-cycle, then quiet period.
        #3;
        do_reset();
        idle(3);

        // Single fetch of 0x0004.
        step(1, 0, 0, 16'h0004, '0, '0, 1, 0);
        idle(3);

        // Write 0x0008<-0x1234, then fetch 0x0007: write issues one cycle first.
        step(0, 0, 1, '0, 16'h0008, 16'h1234, 0, 1);
        step(1, 0, 0, 16'h0007, '0, '0, 1, 0);
        idle(3);

        // Starvation: both held high, pattern wb x4 then fetch.
        nf = 0;
        for (int i = 0; i < 10; i++) begin
            bit fw;
            fw = (i % 5) == 4;
            step(1, 0, 1, 16'(16'h0010 + nf), 16'(16'h0020 + i), 16'(16'hA000 + i), fw, !fw);
            if (fw) nf++;
        end
        idle(3);

        // Fetch accepted, then halt: the accepted fetch still completes,
        // write-backs are served, fetch resumes as soon as halt drops.
        step(1, 0, 0, 16'h0030, '0, '0, 1, 0);
        step(1, 1, 0, 16'h0031, '0, '0, 0, 0);
        step(1, 1, 1, 16'h0031, 16'h0040, 16'hBEEF, 0, 1);
        step(1, 1, 0, 16'h0031, '0, '0, 0, 0);
        step(1, 1, 1, 16'h0031, 16'h0041, 16'hCAFE, 0, 1);
        step(1, 0, 0, 16'h0031, '0, '0, 1, 0);
        idle(3);

        // Streaming fetches: f_valid on consecutive cycles.
        step(1, 0, 0, 16'h0050, '0, '0, 1, 0);
        step(1, 0, 0, 16'h0051, '0, '0, 1, 0);
        step(1, 0, 0, 16'h0052, '0, '0, 1, 0);
        idle(4);

        // Reset one cycle after a fetch grant: that fetch never reports.
        step(1, 0, 0, 16'h0060, '0, '0, 1, 0);
        @(posedge clk);
        #2;
        do_reset();
        idle(3);
        step(1, 0, 0, 16'h0060, '0, '0, 1, 0);
        idle(4);

        chk("queues_drained", 32'(iq.size() + fq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        n_errors++;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
